vadd_ctrl_regs: RTL
===================

Name: vadd_ctrl_regs

Overview:
- AXI-Lite slave register block and command controller for the vector-add kernel on the RAM card.
- Accepts host register writes (start, A/B/C base addresses, vector length), validates them, and latches shadow copies at start.
- Issues a one-cycle start to the vector-add datapath engine and tracks busy/done.
- Raises user interrupt 0 on completion and holds it until the shell acknowledges.

Parameters:
- AXIL_ADDR_WIDTH, 16, AXI-Lite address width.
- ADDR_WIDTH, 64, card memory address width driven to the engine.
- DATA_BYTES, 32, bytes per engine data word (256-bit bus); base addresses must be DATA_BYTES-aligned.
- NUMS_PER_WORD, 8, float32 elements per engine word.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- s_axil_awvalid / s_axil_awready  in/out  1/1  write-address handshake.
- s_axil_awaddr  in  AXIL_ADDR_WIDTH  write byte address.
- s_axil_wvalid / s_axil_wready  in/out  1/1  write-data handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte enables.
- s_axil_bvalid / s_axil_bready  out/in  1/1  write-response handshake.
- s_axil_bresp  out  2  always 2'b00.
- s_axil_arvalid / s_axil_arready  in/out  1/1  read-address handshake.
- s_axil_araddr  in  AXIL_ADDR_WIDTH  read byte address.
- s_axil_rvalid / s_axil_rready  out/in  1/1  read-data handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  always 2'b00.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a_base / eng_b_base / eng_c_base  out  ADDR_WIDTH each  latched base addresses, zero-extended.
- eng_len_words  out  32  latched length in DATA_BYTES words.
- eng_done  in  1  one-cycle completion pulse from the engine.
- usr_irq_req  out  1  interrupt 0 request, level.
- usr_irq_ack  in  1  one-cycle interrupt acknowledge from the shell.

Behaviour:
- Reset: all outputs 0 (ready, valid, rdata, eng_*, usr_irq_req); all registers 0; FSM in IDLE.
- Register map:
  - 0x00 CMD: write with any nonzero wstrb requests a start; reads return 0.
  - 0x04 A_BASE, 0x08 B_BASE, 0x0C C_BASE: 32-bit, byte-strobed, read/write.
  - 0x10 VEC_LEN: float32 element count, byte-strobed, read/write.
  - 0x14 STATUS: read-only. bit0 busy, bit1 done (sticky), bit2 cfg_err (sticky), bit3 start_dropped (sticky).
  - 0x18 IRQ_CLR: write with bit0=1 clears done and usr_irq_req, and clears bits 2 and 3.
  - Unmapped addresses: writes are ignored with OKAY; reads return 0 with OKAY.
- Write channel:
  - AW and W are captured independently; each ready is high while its holding slot is empty and bvalid=0.
  - The register update happens in the cycle after both slots are full. bvalid asserts in that same cycle and holds until bready.
  - Only one write is outstanding at a time.
- Read channel:
  - arready=1 when rvalid=0.
  - rvalid and rdata are registered 1 cycle after the AR handshake and hold until rready.
- Config writes while busy update the live registers only; the engine sees the shadow copies taken at start.
- Start validation happens in the write-commit cycle. A start is rejected (no pulse, cfg_err set) if any of the following holds:
  - VEC_LEN = 0;
  - VEC_LEN mod NUMS_PER_WORD != 0;
  - any base address has a nonzero value in its low log2(DATA_BYTES) bits.
- FSM:
  - IDLE: a valid start latches shadows, sets eng_len_words = VEC_LEN / NUMS_PER_WORD, pulses eng_start for exactly 1 cycle, goes to BUSY.
  - BUSY: a start request sets start_dropped and is otherwise ignored. eng_done goes to DONE.
  - DONE (1 cycle): sets done and usr_irq_req, returns to IDLE.
  - usr_irq_req deasserts on usr_irq_ack or IRQ_CLR.
  - If a set and a clear of done/irq happen in the same cycle, the set wins.
- A start issued in the same cycle that the FSM is in DONE is evaluated as IDLE and is accepted. A new start does not clear done.
- eng_done outside BUSY is ignored.
- Async reset mid-operation returns to IDLE immediately. A pending AXI transaction is discarded, and the master must re-issue it.

Test Plan:
- Write A_BASE=0x0, B_BASE=0x100, C_BASE=0x200, VEC_LEN=64, CMD=0 → one-cycle eng_start with eng_a/b/c_base=0x0/0x100/0x200 and eng_len_words=8; STATUS reads 0x1.
- From BUSY, pulse eng_done → usr_irq_req=1 on the next cycle; STATUS=0x2. Pulse usr_irq_ack → usr_irq_req=0 and STATUS stays 0x2. Write IRQ_CLR=1 → STATUS=0x0.
- VEC_LEN=60, CMD write → no eng_start, STATUS=0x4. Repeat with VEC_LEN=0 → same result. Repeat with B_BASE=0x110 → same result.
- In BUSY, write CMD and then A_BASE=0x400 → STATUS bit3=1, no second eng_start, eng_a_base stays 0x0; A_BASE reads back 0x400.
- Present W two cycles before AW, then hold bready=0 for 3 cycles → single register update, bvalid held for 4 cycles. Read 0x20 → rdata=0.
- Assert rst while BUSY with usr_irq_req=1 → all outputs 0 immediately; a subsequent valid start works normally.

Source files
------------

// File: rtl/vadd_ctrl_regs.sv
// AXI-Lite register block and command controller for the vector-add engine.
// Host writes configuration, CMD launches the engine from shadow copies, and completion raises an interrupt.
module vadd_ctrl_regs #(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_BYTES      = 32,
    parameter int NUMS_PER_WORD   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       eng_start,
    output logic [ADDR_WIDTH-1:0]      eng_a_base,
    output logic [ADDR_WIDTH-1:0]      eng_b_base,
    output logic [ADDR_WIDTH-1:0]      eng_c_base,
    output logic [31:0]                eng_len_words,
    input  logic                       eng_done,
    output logic                       usr_irq_req,
    input  logic                       usr_irq_ack
);

    localparam int ALIGN_BITS = $clog2(DATA_BYTES);
    localparam int NUM_BITS   = $clog2(NUMS_PER_WORD);

    localparam logic [3:0] IDX_CMD     = 4'd0;
    localparam logic [3:0] IDX_A       = 4'd1;
    localparam logic [3:0] IDX_B       = 4'd2;
    localparam logic [3:0] IDX_C       = 4'd3;
    localparam logic [3:0] IDX_LEN     = 4'd4;
    localparam logic [3:0] IDX_STATUS  = 4'd5;
    localparam logic [3:0] IDX_IRQ_CLR = 4'd6;
    localparam logic [3:0] IDX_NONE    = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Word-aligned offsets 0x00..0x18 map to registers; anything else is a hole.
    function automatic logic [3:0] reg_index(input logic [AXIL_ADDR_WIDTH-1:0] addr);
        logic [3:0] idx;
        if (addr[AXIL_ADDR_WIDTH-1:5] != '0 || addr[1:0] != 2'b00 || addr[4:2] == 3'd7)
            idx = IDX_NONE;
        else
            idx = {1'b0, addr[4:2]};
        return idx;
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    logic                       live;
    logic                       aw_full;
    logic                       w_full;
    logic [AXIL_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]                w_data_q;
    logic [3:0]                 w_strb_q;
    logic [31:0]                a_base_r;
    logic [31:0]                b_base_r;
    logic [31:0]                c_base_r;
    logic [31:0]                vec_len_r;
    logic [1:0]                 state;
    logic                       done_r;
    logic                       cfg_err_r;
    logic                       drop_r;
    logic                       wr_commit;
    logic [3:0]                 wr_idx;
    logic                       start_req;
    logic                       irq_clr;
    logic                       cfg_ok;
    logic [31:0]                status_word;
    logic [31:0]                rd_word;

    // live holds the ready outputs low while reset is asserted and for the first cycle after.
    assign s_axil_awready = live && !aw_full && !s_axil_bvalid;
    assign s_axil_wready  = live && !w_full && !s_axil_bvalid;
    assign s_axil_arready = live && !s_axil_rvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;

    assign wr_commit = aw_full && w_full;
    assign wr_idx    = reg_index(aw_addr_q);
    assign start_req = wr_commit && (wr_idx == IDX_CMD) && (w_strb_q != 4'b0000);
    assign irq_clr   = wr_commit && (wr_idx == IDX_IRQ_CLR) && w_data_q[0] && w_strb_q[0];

    assign cfg_ok = (vec_len_r != '0) &&
                    (vec_len_r[NUM_BITS-1:0] == '0) &&
                    (a_base_r[ALIGN_BITS-1:0] == '0) &&
                    (b_base_r[ALIGN_BITS-1:0] == '0) &&
                    (c_base_r[ALIGN_BITS-1:0] == '0);

    assign status_word = {28'd0, drop_r, cfg_err_r, done_r, (state == ST_BUSY)};

    always_comb begin
        rd_word = '0;
        case (reg_index(s_axil_araddr))
            IDX_A:      rd_word = a_base_r;
            IDX_B:      rd_word = b_base_r;
            IDX_C:      rd_word = c_base_r;
            IDX_LEN:    rd_word = vec_len_r;
            IDX_STATUS: rd_word = status_word;
            default:    rd_word = '0;
        endcase
    end

    // AW and W are held in independent one-deep slots; a write commits once both are full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live          <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
        end else begin
            live <= 1'b1;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_full   <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
            if (wr_commit) begin
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                s_axil_bvalid <= 1'b1;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_base_r  <= '0;
            b_base_r  <= '0;
            c_base_r  <= '0;
            vec_len_r <= '0;
        end else if (wr_commit) begin
            case (wr_idx)
                IDX_A:   a_base_r  <= merge_strb(a_base_r, w_data_q, w_strb_q);
                IDX_B:   b_base_r  <= merge_strb(b_base_r, w_data_q, w_strb_q);
                IDX_C:   c_base_r  <= merge_strb(c_base_r, w_data_q, w_strb_q);
                IDX_LEN: vec_len_r <= merge_strb(vec_len_r, w_data_q, w_strb_q);
                default: ;
            endcase
        end
    end

    // Clears are applied first so a same-cycle completion (set) overrides them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            eng_start     <= 1'b0;
            eng_a_base    <= '0;
            eng_b_base    <= '0;
            eng_c_base    <= '0;
            eng_len_words <= '0;
            done_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
            drop_r        <= 1'b0;
            usr_irq_req   <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            if (irq_clr) begin
                done_r      <= 1'b0;
                cfg_err_r   <= 1'b0;
                drop_r      <= 1'b0;
                usr_irq_req <= 1'b0;
            end
            if (usr_irq_ack)
                usr_irq_req <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start_req) begin
                        if (cfg_ok) begin
                            eng_a_base    <= {{(ADDR_WIDTH-32){1'b0}}, a_base_r};
                            eng_b_base    <= {{(ADDR_WIDTH-32){1'b0}}, b_base_r};
                            eng_c_base    <= {{(ADDR_WIDTH-32){1'b0}}, c_base_r};
                            eng_len_words <= vec_len_r >> NUM_BITS;
                            eng_start     <= 1'b1;
                            state         <= ST_BUSY;
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (start_req)
                        drop_r <= 1'b1;
                    if (eng_done) begin
                        state       <= ST_DONE;
                        done_r      <= 1'b1;
                        usr_irq_req <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule
